// File: rtl/sr_seq_pkg.sv
// Shared definitions for the SR latch sequencer.
//   state_t  : controller states
//   OP_SET / OP_RESET : encoding of a requester's op bit
//   max_int  : elaboration-time helper for sizing the shared timer
package sr_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_CHECK = 3'd5
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      : request vector
//   ptr      : highest-priority index for this decision
//   gnt      : one-hot grant (all zero when no request)
//   gnt_idx  : index of the granted requester
//   next_ptr : granted index + 1, wrapping to 0
//   valid    : at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic [PTR_W-1:0]   next_ptr,
    output logic               valid
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
                next_ptr     = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
            end
            idx = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/sr_latch_sequencer.sv
// Sequencer that shares one level-sensitive SR latch between NUM_REQ
// requesters, arbitrating round-robin and driving s/r/en with fixed
// setup, pulse and hold windows, then checking the latch state.
//   clk, rst        : clock, synchronous active-low reset
//   req, op         : per-requester request level and op (1=SET, 0=RESET)
//   gnt, done, busy : one-cycle grant, one-cycle completion, not-idle flag
//   err             : sticky readback mismatch
//   latch_*         : pins of the latch cell (latch_q is its output)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | latch_rst high for INIT_CYC cycles, requests ignored
// ST_IDLE  | latch pins low, grant next requester when any req is set
// ST_SETUP | s/r driven from cur_op, en low, SETUP_CYC cycles
// ST_PULSE | s/r held, en high, PULSE_CYC cycles
// ST_HOLD  | s/r held, en low, HOLD_CYC cycles
// ST_CHECK | pins low, compare latch_q with cur_op, raise done
module sr_latch_sequencer
    import sr_seq_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int INIT_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] op,
    output logic [NUM_REQ-1:0] gnt,
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic               latch_s,
    output logic               latch_r,
    output logic               latch_en,
    output logic               latch_rst,
    input  logic               latch_q
);

    localparam int MAX_CYC = max_int(max_int(SETUP_CYC, PULSE_CYC),
                                     max_int(HOLD_CYC, INIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PTR_W-1:0]   ptr;
    logic               cur_op;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   arb_next;
    logic               arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req      (req),
        .ptr      (ptr),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx),
        .next_ptr (arb_next),
        .valid    (arb_valid)
    );

    // All outputs are registered alongside the state, so s/r only move on
    // the IDLE->SETUP and HOLD->CHECK edges, both of which have en low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_INIT;
            cnt       <= CNT_W'(INIT_CYC - 1);
            ptr       <= '0;
            cur_op    <= OP_RESET;
            gnt       <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            err       <= 1'b0;
            latch_s   <= 1'b0;
            latch_r   <= 1'b0;
            latch_en  <= 1'b0;
            latch_rst <= 1'b1;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (cnt == '0) begin
                        state     <= ST_IDLE;
                        latch_rst <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt     <= arb_gnt;
                        cur_op  <= op[arb_idx];
                        ptr     <= arb_next;
                        latch_s <= op[arb_idx];
                        latch_r <= ~op[arb_idx];
                        busy    <= 1'b1;
                        cnt     <= CNT_W'(SETUP_CYC - 1);
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        latch_en <= 1'b1;
                        cnt      <= CNT_W'(PULSE_CYC - 1);
                        state    <= ST_PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        latch_en <= 1'b0;
                        cnt      <= CNT_W'(HOLD_CYC - 1);
                        state    <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        latch_s <= 1'b0;
                        latch_r <= 1'b0;
                        state   <= ST_CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (latch_q != cur_op) begin
                        err <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_INIT;
                    cnt       <= CNT_W'(INIT_CYC - 1);
                    busy      <= 1'b1;
                    latch_s   <= 1'b0;
                    latch_r   <= 1'b0;
                    latch_en  <= 1'b0;
                    latch_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
